// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back unit: CSR indices, FSM states and
// the latched retire record.
package wbu_pkg;

   localparam logic [1:0]  CSR_MSTATUS    = 2'd0;
   localparam logic [1:0]  CSR_MTVEC      = 2'd1;
   localparam logic [1:0]  CSR_MEPC       = 2'd2;
   localparam logic [1:0]  CSR_MCAUSE     = 2'd3;
   localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

   typedef enum logic [1:0] {IDLE, COMMIT, SEND, HALT} state_t;

   typedef struct packed {
      logic [31:0] wd;
      logic [31:0] csr_wd;
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic [4:0]  rd;
      logic [1:0]  csr_rd;
      logic        reg_write_en;
      logic        csreg_write_en;
      logic        ecall;
      logic        ebreak;
   } retire_t;

endpackage

// File: rtl/wbu_if.sv
// Retire handshake bundle from the load/store unit (master) into the
// write-back unit (slave).
interface wbu_if;
   logic        wbu_receive_valid;
   logic        wbu_receive_ready;
   logic [31:0] wd;
   logic [31:0] csr_wd;
   logic [4:0]  rd;
   logic [1:0]  csr_rd;
   logic        reg_write_en;
   logic        csreg_write_en;
   logic        ecall;
   logic        ebreak;
   logic [31:0] pc;
   logic [31:0] pc_next;

   modport master (
      output wbu_receive_valid, wd, csr_wd, rd, csr_rd, reg_write_en,
             csreg_write_en, ecall, ebreak, pc, pc_next,
      input  wbu_receive_ready
   );

   modport slave (
      input  wbu_receive_valid, wd, csr_wd, rd, csr_rd, reg_write_en,
             csreg_write_en, ecall, ebreak, pc, pc_next,
      output wbu_receive_ready
   );
endinterface

// File: rtl/wbu_gpr_file.sv
// GPR file: one synchronous write port, two asynchronous read ports and a
// fixed a0 (x10) tap; x0 and registers at or above NR_GPR read as zero.
module gpr_file #(
   parameter int NR_GPR = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   output logic [31:0] a0
);

   logic [31:0] regs [32];

   assign regs[0] = '0;

   // Absent registers have no storage, so writes to them vanish naturally.
   for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      if (gi < NR_GPR) begin : g_impl
         logic [31:0] q_reg;
         always_ff @(posedge clk) begin
            if (rst)
               q_reg <= '0;
            else if (we && waddr == 5'(gi))
               q_reg <= wdata;
         end
         assign regs[gi] = q_reg;
      end else begin : g_absent
         assign regs[gi] = '0;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];
   assign a0     = regs[10];

endmodule

// File: rtl/wbu.sv
// Write-back stage: commits GPR/CSR writes, handles ecall/ebreak, redirects
// the IFU. Optional WBU_BYPASS_EN forwards pending writes to reads in COMMIT.
module wbu
   import wbu_pkg::*;
#(
   parameter int          NR_GPR      = 32,
   parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
   input  logic        clk,
   input  logic        rst,
   wbu_if.slave        lsu,
   output logic        wbu_send_valid,
   input  logic        ifu_receive_ready,
   output logic [31:0] pc_redirect,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic [1:0]  csr_raddr,
   output logic [31:0] csr_rdata,
   output logic [4:0]  rd_wbu_to_idu,
   output logic        wbu_state,
   output logic        halt,
   output logic [31:0] halt_code
);

   state_t      state_reg;
   retire_t     lat_reg;
   logic        ready_reg, send_valid_reg, halt_reg;
   logic [31:0] pc_redirect_reg, halt_code_reg;

   logic        commit, gpr_we;
   logic [31:0] rf_rdata1, rf_rdata2, rf_a0;
   logic [31:0] csr_reg   [4];
   logic [31:0] csr_wdata [4];
   logic [3:0]  csr_we;

   assign commit = (state_reg == COMMIT);
   assign gpr_we = commit && lat_reg.reg_write_en;

   gpr_file #(.NR_GPR(NR_GPR)) u_gpr (
      .clk    (clk),
      .rst    (rst),
      .we     (gpr_we),
      .waddr  (lat_reg.rd),
      .wdata  (lat_reg.wd),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2),
      .a0     (rf_a0)
   );

   // ecall claims mepc/mcause outright, masking any explicit write to them.
   for (genvar gi = 0; gi < 4; gi++) begin : g_csr
      localparam logic [1:0]  IDX     = 2'(gi);
      localparam logic [31:0] RST_VAL = (IDX == CSR_MSTATUS) ? MSTATUS_RST : 32'd0;
      logic        ecall_hit;
      logic [31:0] q_reg;

      assign ecall_hit     = lat_reg.ecall && (IDX == CSR_MEPC || IDX == CSR_MCAUSE);
      assign csr_we[gi]    = commit && (ecall_hit ||
                             (lat_reg.csreg_write_en && lat_reg.csr_rd == IDX));
      assign csr_wdata[gi] = !ecall_hit ? lat_reg.csr_wd :
                             (IDX == CSR_MEPC) ? lat_reg.pc : MCAUSE_ECALL_M;

      always_ff @(posedge clk) begin
         if (rst)
            q_reg <= RST_VAL;
         else if (csr_we[gi])
            q_reg <= csr_wdata[gi];
      end
      assign csr_reg[gi] = q_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         lat_reg         <= '0;
         ready_reg       <= 1'b1;
         send_valid_reg  <= 1'b0;
         halt_reg        <= 1'b0;
         pc_redirect_reg <= '0;
         halt_code_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (lsu.wbu_receive_valid) begin
                  lat_reg <= '{wd: lsu.wd, csr_wd: lsu.csr_wd, pc: lsu.pc,
                               pc_next: lsu.pc_next, rd: lsu.rd, csr_rd: lsu.csr_rd,
                               reg_write_en: lsu.reg_write_en,
                               csreg_write_en: lsu.csreg_write_en,
                               ecall: lsu.ecall, ebreak: lsu.ebreak};
                  ready_reg <= 1'b0;
                  state_reg <= COMMIT;
               end
            end
            COMMIT: begin
               if (lat_reg.ebreak) begin
                  // a0 as it stands once this instruction's own write lands
                  halt_code_reg <= (gpr_we && lat_reg.rd == 5'd10) ? lat_reg.wd : rf_a0;
                  halt_reg      <= 1'b1;
                  state_reg     <= HALT;
               end else begin
                  pc_redirect_reg <= lat_reg.ecall ? csr_reg[CSR_MTVEC] : lat_reg.pc_next;
                  send_valid_reg  <= 1'b1;
                  state_reg       <= SEND;
               end
            end
            SEND: begin
               if (ifu_receive_ready) begin
                  send_valid_reg <= 1'b0;
                  ready_reg      <= 1'b1;
                  state_reg      <= IDLE;
               end
            end
            HALT: ;
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef WBU_BYPASS_EN
   logic fwd_ok;
   assign fwd_ok    = gpr_we && lat_reg.rd != 5'd0 && {27'd0, lat_reg.rd} < NR_GPR;
   assign rs1_data  = (fwd_ok && rs1_addr == lat_reg.rd) ? lat_reg.wd : rf_rdata1;
   assign rs2_data  = (fwd_ok && rs2_addr == lat_reg.rd) ? lat_reg.wd : rf_rdata2;
   assign csr_rdata = csr_we[csr_raddr] ? csr_wdata[csr_raddr] : csr_reg[csr_raddr];
`else
   assign rs1_data  = rf_rdata1;
   assign rs2_data  = rf_rdata2;
   assign csr_rdata = csr_reg[csr_raddr];
`endif

   assign lsu.wbu_receive_ready = ready_reg;
   assign wbu_send_valid        = send_valid_reg;
   assign pc_redirect           = pc_redirect_reg;
   assign halt                  = halt_reg;
   assign halt_code             = halt_code_reg;
   assign wbu_state             = (state_reg != IDLE);
   assign rd_wbu_to_idu         = (state_reg != IDLE && lat_reg.reg_write_en) ? lat_reg.rd : 5'd0;

endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: randomized retires checked against an
// architectural model of the GPR/CSR state and the expected next-PC stream.
module tb_wbu;
   import wbu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wbu_send_valid, ifu_receive_ready;
   logic [31:0] pc_redirect, rs1_data, rs2_data, csr_rdata, halt_code;
   logic [4:0]  rs1_addr, rs2_addr, rd_wbu_to_idu;
   logic [1:0]  csr_raddr;
   logic        wbu_state, halt;

   always #5 clk = ~clk;

   wbu_if bus ();

   wbu dut (
      .clk               (clk),
      .rst               (rst),
      .lsu               (bus),
      .wbu_send_valid    (wbu_send_valid),
      .ifu_receive_ready (ifu_receive_ready),
      .pc_redirect       (pc_redirect),
      .rs1_addr          (rs1_addr),
      .rs2_addr          (rs2_addr),
      .rs1_data          (rs1_data),
      .rs2_data          (rs2_data),
      .csr_raddr         (csr_raddr),
      .csr_rdata         (csr_rdata),
      .rd_wbu_to_idu     (rd_wbu_to_idu),
      .wbu_state         (wbu_state),
      .halt              (halt),
      .halt_code         (halt_code)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_gpr [32];
   logic [31:0] m_csr [4];
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_csr[0] = 32'h0000_1800;
      m_csr[1] = 32'd0;
      m_csr[2] = 32'd0;
      m_csr[3] = 32'd0;
   endfunction

   // Architectural effect of one retired instruction.
   function automatic void model_commit(input retire_t t);
      if (t.reg_write_en && t.rd != 5'd0) m_gpr[t.rd] = t.wd;
      if (t.csreg_write_en) m_csr[t.csr_rd] = t.csr_wd;
      if (t.ecall) begin
         m_csr[2] = t.pc;
         m_csr[3] = 32'd11;
      end
   endfunction

   function automatic retire_t rand_txn();
      retire_t t;
      t.wd             = $urandom;
      t.csr_wd         = $urandom;
      t.pc             = $urandom;
      t.pc_next        = $urandom;
      t.rd             = 5'($urandom);
      t.csr_rd         = 2'($urandom);
      t.reg_write_en   = ($urandom % 4) != 0;
      t.csreg_write_en = ($urandom % 3) == 0;
      t.ecall          = ($urandom % 8) == 0;
      t.ebreak         = 1'b0;
      return t;
   endfunction

   task automatic drive(input retire_t t);
      bus.wd             = t.wd;
      bus.csr_wd         = t.csr_wd;
      bus.pc             = t.pc;
      bus.pc_next        = t.pc_next;
      bus.rd             = t.rd;
      bus.csr_rd         = t.csr_rd;
      bus.reg_write_en   = t.reg_write_en;
      bus.csreg_write_en = t.csreg_write_en;
      bus.ecall          = t.ecall;
      bus.ebreak         = t.ebreak;
      ifu_receive_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.wbu_receive_valid = 1'b0;
      ifu_receive_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      model_reset();
      exp_q.delete();
   endtask

   task automatic check_state();
      logic [4:0] a1, a2;
      logic [1:0] c;
      a1 = 5'($urandom);
      a2 = 5'($urandom);
      c  = 2'($urandom);
      rs1_addr = a1;
      rs2_addr = a2;
      csr_raddr = c;
      #1;
      chk("gpr_rs1", rs1_data, m_gpr[a1]);
      chk("gpr_rs2", rs2_data, m_gpr[a2]);
      chk("csr_read", csr_rdata, m_csr[c]);
   endtask

   task automatic check_csr_all();
      for (int i = 0; i < 4; i++) begin
         csr_raddr = 2'(i);
         #1;
         chk("csr_all", csr_rdata, m_csr[i]);
      end
   endtask

   task automatic issue(input retire_t t, input int hold);
      int          n;
      logic [31:0] old_gpr [32];
      logic [31:0] old_csr [4];
      logic [31:0] exp_pc;
      n = 0;
      while (!bus.wbu_receive_ready && n < 50) begin
         step();
         n++;
      end
      chk("accept_ready", 32'(bus.wbu_receive_ready), 32'd1);
      drive(t);
      bus.wbu_receive_valid = 1'b1;
      step();
      bus.wbu_receive_valid = 1'b0;
      chk("commit_busy", {30'd0, bus.wbu_receive_ready, wbu_state}, 32'd1);
      old_gpr = m_gpr;
      old_csr = m_csr;
      exp_pc = t.ecall ? m_csr[1] : t.pc_next;
      model_commit(t);
      rs2_addr = t.rd;
      csr_raddr = t.csr_rd;
      #1;
`ifdef WBU_BYPASS_EN
      chk("commit_read_gpr", rs2_data, m_gpr[t.rd]);
      chk("commit_read_csr", csr_rdata, m_csr[t.csr_rd]);
`else
      chk("commit_read_gpr", rs2_data, old_gpr[t.rd]);
      chk("commit_read_csr", csr_rdata, old_csr[t.csr_rd]);
`endif
      if (!t.ebreak) exp_q.push_back(exp_pc);
      step();
      if (t.ebreak) begin
         chk("halt", 32'(halt), 32'd1);
         chk("halt_code", halt_code, m_gpr[10]);
         chk("halt_send_valid", 32'(wbu_send_valid), 32'd0);
         check_state();
         return;
      end
      chk("send_valid", 32'(wbu_send_valid), 32'd1);
      chk("rd_to_idu", 32'(rd_wbu_to_idu), 32'(t.reg_write_en ? t.rd : 5'd0));
      check_state();
      for (int h = 0; h < hold; h++) begin
         // offer a junk retire that must not be accepted while busy
         bus.wbu_receive_valid = 1'b1;
         bus.rd = 5'($urandom);
         bus.wd = $urandom;
         bus.reg_write_en = 1'b1;
         step();
         chk("hold_pc_redirect", pc_redirect, exp_pc);
         chk("hold_ready", 32'(bus.wbu_receive_ready), 32'd0);
         chk("hold_busy", 32'(wbu_state), 32'd1);
         chk("hold_send_valid", 32'(wbu_send_valid), 32'd1);
      end
      bus.wbu_receive_valid = 1'b0;
      ifu_receive_ready = 1'b1;
      step();
      ifu_receive_ready = 1'b0;
      chk("idle_ready", 32'(bus.wbu_receive_ready), 32'd1);
      chk("idle_send_valid", 32'(wbu_send_valid), 32'd0);
      chk("idle_rd_to_idu", 32'(rd_wbu_to_idu), 32'd0);
   endtask

   // Monitor: every IFU handshake consumes one expected next PC.
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && wbu_send_valid && ifu_receive_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_send", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pc_redirect", pc_redirect, e);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      retire_t t;
      bus.wbu_receive_valid = 1'b0;
      drive('0);
      rs1_addr = '0;
      rs2_addr = '0;
      csr_raddr = '0;
      do_reset();

      // reset state
      chk("rst_ready", 32'(bus.wbu_receive_ready), 32'd1);
      chk("rst_send_valid", 32'(wbu_send_valid), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_halt_code", halt_code, 32'd0);
      chk("rst_pc_redirect", pc_redirect, 32'd0);
      chk("rst_rd_to_idu", 32'(rd_wbu_to_idu), 32'd0);
      chk("rst_state", 32'(wbu_state), 32'd0);
      check_csr_all();

      // plain GPR write with redirect held for two cycles
      t = '0; t.rd = 5'd5; t.wd = 32'hDEADBEEF; t.reg_write_en = 1'b1; t.pc_next = 32'h8000_0004;
      issue(t, 2);
      rs1_addr = 5'd5; #1;
      chk("x5_after", rs1_data, 32'hDEADBEEF);

      // write to x0 discarded
      t = '0; t.rd = 5'd0; t.wd = 32'h1234; t.reg_write_en = 1'b1; t.pc_next = 32'h8000_0008;
      issue(t, 0);
      rs1_addr = 5'd0; #1;
      chk("x0_zero", rs1_data, 32'd0);

      // mtvec then ecall
      t = '0; t.csreg_write_en = 1'b1; t.csr_rd = CSR_MTVEC; t.csr_wd = 32'h8000_0100; t.pc_next = 32'h8000_000C;
      issue(t, 0);
      t = '0; t.ecall = 1'b1; t.pc = 32'h8000_0020; t.pc_next = 32'h8000_0024;
      t.csreg_write_en = 1'b1; t.csr_rd = CSR_MEPC; t.csr_wd = 32'h1111_1111;
      issue(t, 0);
      check_csr_all();

      // long IFU stall
      t = rand_txn(); t.ecall = 1'b0;
      issue(t, 5);

      // x7 old value vs pending write during COMMIT
      t = '0; t.rd = 5'd7; t.wd = 32'h11; t.reg_write_en = 1'b1; t.pc_next = 32'h10;
      issue(t, 0);
      t.wd = 32'h55; t.pc_next = 32'h14;
      issue(t, 1);

      // randomized traffic
      for (int i = 0; i < 150; i++) issue(rand_txn(), int'($urandom % 4));

      // reset during COMMIT discards the instruction
      t = '0; t.rd = 5'd9; t.wd = 32'hCAFE; t.reg_write_en = 1'b1;
      t.csreg_write_en = 1'b1; t.csr_rd = CSR_MSTATUS; t.csr_wd = 32'd0;
      drive(t);
      bus.wbu_receive_valid = 1'b1;
      step();
      bus.wbu_receive_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      rs1_addr = 5'd9; csr_raddr = CSR_MSTATUS; #1;
      chk("rst_mid_x9", rs1_data, 32'd0);
      chk("rst_mid_mstatus", csr_rdata, 32'h0000_1800);
      chk("rst_mid_ready", 32'(bus.wbu_receive_ready), 32'd1);
      chk("rst_mid_state", 32'(wbu_state), 32'd0);

      // ebreak with a0 = 0; its own x3 write still lands
      t = '0; t.ebreak = 1'b1; t.rd = 5'd3; t.wd = 32'h33; t.reg_write_en = 1'b1;
      issue(t, 0);
      rs1_addr = 5'd3; #1;
      chk("ebreak_x3", rs1_data, 32'h33);
      t = rand_txn();
      drive(t);
      bus.wbu_receive_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halted_ready", 32'(bus.wbu_receive_ready), 32'd0);
         chk("halted_halt", 32'(halt), 32'd1);
         chk("halted_send_valid", 32'(wbu_send_valid), 32'd0);
      end
      bus.wbu_receive_valid = 1'b0;

      // ebreak whose own write targets a0
      do_reset();
      t = '0; t.rd = 5'd10; t.wd = 32'h77; t.reg_write_en = 1'b1; t.pc_next = 32'h20;
      issue(t, 0);
      t = '0; t.ebreak = 1'b1; t.rd = 5'd10; t.wd = 32'h99; t.reg_write_en = 1'b1;
      issue(t, 0);
      chk("halt_code_own_write", halt_code, 32'h99);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
